// File: rtl/key_op_scheduler.sv
// Key-event scheduler between the PS/2 decoder and the game-state engine: edge detect, op FIFO,
// valid/ack issue and post-ack gap. Define AUTO_REPEAT_EN to add the held-key repeater.
module key_op_scheduler #(
  parameter int         DEPTH      = 4,
  parameter int         GAP_CYCLES = 16,
  parameter logic [4:0] FLUSH_CODE = 5'h1F,
  parameter int         RPT_DELAY  = 2500,
  parameter int         RPT_PERIOD = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_ready,
  input  logic [4:0]               key_code,
  input  logic                     op_ack,
  output logic [4:0]               op,
  output logic                     op_valid,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gDepthCheck
    $error("key_op_scheduler: DEPTH must be a power of two >= 2");
  end
  if ((RPT_DELAY < 1) || (RPT_PERIOD < 1)) begin : gRptCheck
    $error("key_op_scheduler: RPT_DELAY and RPT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          stateNext_s;
  logic            keyReadyD_r;
  logic [4:0]      mem_r [DEPTH];
  logic [PW-1:0]   headPtr_r;
  logic [PW-1:0]   tailPtr_r;
  logic [GW-1:0]   gapCnt_r;

  logic            rise_s;
  logic            ev_s;
  logic            flushEv_s;
  logic            pushReq_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic            drop_s;
  logic            issue_s;
  logic            retire_s;
  logic            gapRun_s;

  assign rise_s = key_ready & ~keyReadyD_r;

  // Delayed copy of key_ready for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keyReadyD_r <= 1'b0;
    end else begin
      keyReadyD_r <= key_ready;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [4:0]    codeD_r;
  logic [RW-1:0] rptCnt_r;
  logic          held_s;
  logic          rptFire_s;

  // Held means the same code stayed up since last cycle; anything else restarts the delay
  assign held_s    = key_ready & keyReadyD_r & (key_code == codeD_r);
  assign rptFire_s = held_s & (rptCnt_r == RW'(0)) & (key_code != FLUSH_CODE);
  assign ev_s      = rise_s | rptFire_s;

  // Hold counter: cycles remaining until the next synthetic repeat event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codeD_r  <= 5'd0;
      rptCnt_r <= RW'(RPT_DELAY - 1);
    end else begin
      codeD_r <= key_code;
      if (!held_s) begin
        rptCnt_r <= RW'(RPT_DELAY - 1);
      end else if (rptCnt_r == RW'(0)) begin
        rptCnt_r <= RW'(RPT_PERIOD - 1);
      end else begin
        rptCnt_r <= rptCnt_r - RW'(1);
      end
    end
  end
`else
  assign ev_s = rise_s;
`endif

  // A flush rebuilds the queue, so it also blocks the IDLE pop of that cycle
  assign flushEv_s = ev_s & (key_code == FLUSH_CODE);
  assign pushReq_s = ev_s & (key_code != 5'd0) & ~flushEv_s;
  assign full_s    = (q_count == DEPTH_C);
  assign pop_s     = (state_r == S_IDLE) & (q_count != CW'(0)) & ~flushEv_s;
  assign push_s    = pushReq_s & (~full_s | pop_s);
  assign drop_s    = pushReq_s & full_s & ~pop_s;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 5'd0;
      end
      headPtr_r <= PW'(0);
      tailPtr_r <= PW'(0);
      q_count   <= CW'(0);
    end else if (flushEv_s) begin
      mem_r[headPtr_r] <= FLUSH_CODE;
      tailPtr_r        <= headPtr_r + PW'(1);
      q_count          <= CW'(1);
    end else begin
      if (push_s) begin
        mem_r[tailPtr_r] <= key_code;
        tailPtr_r        <= tailPtr_r + PW'(1);
      end
      if (pop_s) begin
        headPtr_r <= headPtr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Sticky drop flag, cleared only by a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flushEv_s) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pop_s) stateNext_s = S_ISSUE;
        else       stateNext_s = S_IDLE;
      end
      S_ISSUE: begin
        if (op_ack) stateNext_s = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        else        stateNext_s = S_ISSUE;
      end
      S_GAP: begin
        if (gapCnt_r == GAP_LAST) stateNext_s = S_IDLE;
        else                      stateNext_s = S_GAP;
      end
      default: stateNext_s = S_IDLE;
    endcase
  end

  // FSM output strobes
  always_comb begin
    issue_s  = 1'b0;
    retire_s = 1'b0;
    gapRun_s = 1'b0;
    case (state_r)
      S_IDLE:  issue_s  = pop_s;
      S_ISSUE: retire_s = op_ack;
      S_GAP:   gapRun_s = 1'b1;
      default: begin
        issue_s  = 1'b0;
        retire_s = 1'b0;
        gapRun_s = 1'b0;
      end
    endcase
  end

  // Post-ack gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gapCnt_r <= GW'(0);
    end else if (retire_s) begin
      gapCnt_r <= GW'(0);
    end else if (gapRun_s) begin
      gapCnt_r <= (gapCnt_r == GAP_LAST) ? GW'(0) : gapCnt_r + GW'(1);
    end else begin
      gapCnt_r <= gapCnt_r;
    end
  end

  // Registered op/op_valid; op keeps its last value after the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= 5'd0;
      op_valid <= 1'b0;
    end else if (issue_s) begin
      op       <= mem_r[headPtr_r];
      op_valid <= 1'b1;
    end else if (retire_s) begin
      op_valid <= 1'b0;
    end else begin
      op       <= op;
      op_valid <= op_valid;
    end
  end

endmodule

// File: tb/tb_key_op_scheduler.sv
// Randomized and directed bench for key_op_scheduler against a queue-based reference model.
module tb_key_op_scheduler;

  localparam int         DEPTH = 4;
  localparam int         GAP   = 16;
  localparam logic [4:0] FLUSH = 5'h1F;
  localparam int         RPTD  = 20;
  localparam int         RPTP  = 10;
`ifdef AUTO_REPEAT_EN
  localparam int EXP_HELD = 4;
`else
  localparam int EXP_HELD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_ready = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       op_ack = 1'b0;
  logic [4:0] op;
  logic       op_valid;
  logic [2:0] q_count;
  logic       overflow;

  key_op_scheduler #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP), .FLUSH_CODE(FLUSH), .RPT_DELAY(RPTD), .RPT_PERIOD(RPTP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_ready(key_ready), .key_code(key_code), .op_ack(op_ack),
    .op(op), .op_valid(op_valid), .q_count(q_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // reference model state
  logic [4:0] mq[$];
  logic [4:0] mOp;
  logic       mValid;
  logic       mOv;
  logic       mKrD;
  logic [4:0] mCodeD;
  int         mReadyAt;
  int         mHold;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOp = 5'd0; mValid = 1'b0; mOv = 1'b0; mKrD = 1'b0; mCodeD = 5'd0;
    mReadyAt = 0; mHold = 0;
  endtask

  task automatic modelEdge(input logic kr, input logic [4:0] kc, input logic ak);
    logic ev, syn, isFlush, isPush, issue;
    syn = 1'b0;
`ifdef AUTO_REPEAT_EN
    if (kr && mKrD && kc == mCodeD) mHold++;
    else mHold = 0;
    syn = (mHold >= RPTD) && (((mHold - RPTD) % RPTP) == 0) && (kc != FLUSH);
`endif
    ev      = (kr && !mKrD) || syn;
    isFlush = ev && (kc == FLUSH);
    isPush  = ev && (kc != 5'd0) && !isFlush;
    issue   = !mValid && (cyc >= mReadyAt) && (mq.size() > 0) && !isFlush;
    if (mValid && ak) begin
      mValid = 1'b0;
      mReadyAt = cyc + GAP + 1;
    end else if (issue) begin
      mOp = mq.pop_front();
      mValid = 1'b1;
    end
    if (isFlush) begin
      mq.delete();
      mq.push_back(FLUSH);
      mOv = 1'b0;
    end else if (isPush) begin
      if (mq.size() < DEPTH) mq.push_back(kc);
      else mOv = 1'b1;
    end
    mKrD = kr; mCodeD = kc;
    cyc++;
  endtask

  task automatic step(input logic kr, input logic [4:0] kc, input logic ak);
    key_ready = kr; key_code = kc; op_ack = ak;
    modelEdge(kr, kc, ak);
    @(posedge clk); #1;
    check("op", 32'(op), 32'(mOp));
    check("op_valid", 32'(op_valid), 32'(mValid));
    check("q_count", 32'(q_count), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(mOv));
  endtask

  task automatic pulse(input logic [4:0] c);
    step(1'b1, c, 1'b0);
    step(1'b0, 5'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0);
  endtask

  task automatic waitValid();
    for (int k = 0; k < 40 && !op_valid; k++) step(1'b0, 5'd0, 1'b0);
    check("wait_op_valid", 32'(op_valid), 32'd1);
  endtask

  task automatic asyncReset();
    rst_n = 1'b0;
    #2;
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    modelReset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises;
    logic prevV, krN, akN;
    logic [4:0] kcN;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_op_valid", 32'(op_valid), 32'd0);
    check("reset_q_count", 32'(q_count), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_op", 32'(op), 32'd0);

    // single op, 2-cycle latency, then the post-ack gap
    step(1'b1, 5'h03, 1'b0);
    check("t1_count_after_edge", 32'(q_count), 32'd1);
    step(1'b0, 5'd0, 1'b0);
    check("t1_valid_latency", 32'(op_valid), 32'd1);
    check("t1_op", 32'(op), 32'd3);
    step(1'b0, 5'd0, 1'b1);
    step(1'b1, 5'h04, 1'b0);
    n = 1;
    while (!op_valid && n < 40) begin
      step(1'b0, 5'd0, 1'b0);
      n++;
    end
    check("t1_gap_latency", 32'(n), 32'd17);
    step(1'b0, 5'd0, 1'b1);
    idle(20);

    // fill, overflow, ordered drain
    for (int c = 1; c <= 5; c++) pulse(5'(c));
    check("t2_count_full", 32'(q_count), 32'd4);
    check("t2_op_head", 32'(op), 32'd1);
    check("t2_no_overflow", 32'(overflow), 32'd0);
    pulse(5'd6);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_count_after_drop", 32'(q_count), 32'd4);
    for (int e = 2; e <= 5; e++) begin
      step(1'b0, 5'd0, 1'b1);
      waitValid();
      check("t2_drain_order", 32'(op), 32'(e));
    end
    step(1'b0, 5'd0, 1'b1);
    idle(20);

    // flush replaces the queue and clears overflow
    pulse(5'd7);
    pulse(5'd2);
    pulse(5'd3);
    check("t3_count_before", 32'(q_count), 32'd2);
    step(1'b1, FLUSH, 1'b0);
    check("t3_count_flush", 32'(q_count), 32'd1);
    check("t3_overflow_clr", 32'(overflow), 32'd0);
    check("t3_op_kept", 32'(op), 32'd7);
    step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b1);
    waitValid();
    check("t3_next_op", 32'(op), 32'h1F);

    // push and pop on the same edge while full
    for (int c = 1; c <= 4; c++) pulse(5'(c));
    check("t4_full", 32'(q_count), 32'd4);
    step(1'b0, 5'd0, 1'b1);
    idle(16);
    step(1'b1, 5'd9, 1'b0);
    check("t4_count_stays", 32'(q_count), 32'd4);
    check("t4_no_drop", 32'(overflow), 32'd0);
    check("t4_issued", 32'(op_valid), 32'd1);
    check("t4_op", 32'(op), 32'd1);
    step(1'b0, 5'd0, 1'b0);

    // reset in the middle of a handshake
    asyncReset();
    idle(30);
    check("t5_no_stale", 32'(op_valid), 32'd0);

    // held key with auto-ack
    rises = 0;
    prevV = op_valid;
    for (int i = 0; i < 45; i++) begin
      step(1'b1, 5'h02, op_valid);
      if (op_valid && !prevV) rises++;
      prevV = op_valid;
    end
    for (int i = 0; i < 120; i++) begin
      step(1'b0, 5'd0, op_valid);
      if (op_valid && !prevV) rises++;
      prevV = op_valid;
    end
    check("t6_held_events", 32'(rises), 32'(EXP_HELD));

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      krN = ($urandom_range(0, 3) == 0) ? !key_ready : key_ready;
      if (!key_ready || $urandom_range(0, 7) == 0) kcN = 5'($urandom_range(0, 31));
      else kcN = key_code;
      akN = 1'($urandom_range(0, 1));
      step(krN, kcN, akN);
      if (i == 450) asyncReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
